// File: rtl/div_arb_pkg.sv
// Shared types and constants for the two-requester divider arbiter.
package div_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Requester index (0 or 1)
  typedef logic owner_t;

  localparam owner_t OWNER_0 = 1'b0;
  localparam owner_t OWNER_1 = 1'b1;

  // Quiet NaN returned when the watchdog aborts a job
  localparam logic [31:0] QNAN = 32'hFFC0_0000;

endpackage

// File: rtl/div_share_arbiter_rr_arb2.sv
// Two-way round-robin grant. When both requesters are pending, the one
// that was not granted last wins; a lone requester always wins.
module rr_arb2
  import div_arb_pkg::*;
(
  input  logic       stb0,
  input  logic       stb1,
  input  owner_t     last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // One-hot grant selection
  always_comb begin
    grant = 2'b00;
    if (!enable) begin
      grant = 2'b00;
    end else if (stb0 && stb1) begin
      grant = (last_grant == OWNER_1) ? 2'b01 : 2'b10;
    end else if (stb0) begin
      grant = 2'b01;
    end else if (stb1) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one single-precision divider between two requesters. Operand pairs
// are accepted round-robin, fed through the divider's a/b/z handshakes, and
// the quotient is returned to the owner. A watchdog resets a stalled divider
// and answers the owner with a quiet NaN and an error flag.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_stb,
  output logic             req0_ack,
  output logic [WIDTH-1:0] resp0_z,
  output logic             resp0_err,
  output logic             resp0_stb,
  input  logic             resp0_ack,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_stb,
  output logic             req1_ack,
  output logic [WIDTH-1:0] resp1_z,
  output logic             resp1_err,
  output logic             resp1_stb,
  input  logic             resp1_ack,
  output logic [WIDTH-1:0] div_a,
  output logic             div_a_stb,
  input  logic             div_a_ack,
  output logic [WIDTH-1:0] div_b,
  output logic             div_b_stb,
  input  logic             div_b_ack,
  input  logic [WIDTH-1:0] div_z,
  input  logic             div_z_stb,
  output logic             div_z_ack,
  output logic             div_rst,
  output logic             busy
);

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WD_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WD_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WD_ZERO  = CNT_W'(0);
  localparam logic [WIDTH-1:0] Z_NAN    = WIDTH'(QNAN);
  localparam logic [WIDTH-1:0] Z_ZERO   = WIDTH'(0);

  state_t           state_r, state_s;
  owner_t           owner_r, owner_s;
  owner_t           last_grant_r, last_grant_s;
  logic [WIDTH-1:0] div_a_r, div_a_s;
  logic [WIDTH-1:0] div_b_r, div_b_s;
  logic             div_a_stb_r, div_a_stb_s;
  logic             div_b_stb_r, div_b_stb_s;
  logic             div_z_ack_r, div_z_ack_s;
  logic [CNT_W-1:0] wd_cnt_r, wd_cnt_s;
  logic [WIDTH-1:0] resp0_z_r, resp0_z_s;
  logic             resp0_err_r, resp0_err_s;
  logic             resp0_stb_r, resp0_stb_s;
  logic [WIDTH-1:0] resp1_z_r, resp1_z_s;
  logic             resp1_err_r, resp1_err_s;
  logic             resp1_stb_r, resp1_stb_s;

  logic [1:0] grant_s;
  logic       req0_xfer_s;
  logic       req1_xfer_s;
  logic       z_xfer_s;
  logic       wd_fire_s;
  logic       resp_xfer_s;

  rr_arb2 u_rr_arb2 (
    .stb0       (req0_stb),
    .stb1       (req1_stb),
    .last_grant (last_grant_r),
    .enable     (state_r == IDLE),
    .grant      (grant_s)
  );

  assign req0_ack    = grant_s[0];
  assign req1_ack    = grant_s[1];
  assign req0_xfer_s = req0_stb && grant_s[0];
  assign req1_xfer_s = req1_stb && grant_s[1];
  assign z_xfer_s    = (state_r == WAIT_Z) && div_z_stb && div_z_ack_r;
  assign wd_fire_s   = (state_r == WAIT_Z) && !z_xfer_s && (wd_cnt_r == WD_LIMIT);
  assign resp_xfer_s = (state_r == RESP) &&
                       ((owner_r == OWNER_0) ? (resp0_stb_r && resp0_ack)
                                             : (resp1_stb_r && resp1_ack));

  // The divider is reset together with the arbiter and on a watchdog abort
  assign div_rst   = rst | wd_fire_s;
  assign busy      = (state_r != IDLE);
  assign div_a     = div_a_r;
  assign div_b     = div_b_r;
  assign div_a_stb = div_a_stb_r;
  assign div_b_stb = div_b_stb_r;
  assign div_z_ack = div_z_ack_r;
  assign resp0_z   = resp0_z_r;
  assign resp0_err = resp0_err_r;
  assign resp0_stb = resp0_stb_r;
  assign resp1_z   = resp1_z_r;
  assign resp1_err = resp1_err_r;
  assign resp1_stb = resp1_stb_r;

  // Next-state and next-output computation for the job sequencer
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    div_a_s      = div_a_r;
    div_b_s      = div_b_r;
    div_a_stb_s  = div_a_stb_r;
    div_b_stb_s  = div_b_stb_r;
    div_z_ack_s  = div_z_ack_r;
    wd_cnt_s     = wd_cnt_r;
    resp0_z_s    = resp0_z_r;
    resp0_err_s  = resp0_err_r;
    resp0_stb_s  = resp0_stb_r;
    resp1_z_s    = resp1_z_r;
    resp1_err_s  = resp1_err_r;
    resp1_stb_s  = resp1_stb_r;

    case (state_r)
      IDLE: begin
        if (req0_xfer_s) begin
          div_a_s     = req0_a;
          div_b_s     = req0_b;
          owner_s     = OWNER_0;
          div_a_stb_s = 1'b1;
          state_s     = SEND_A;
        end else if (req1_xfer_s) begin
          div_a_s     = req1_a;
          div_b_s     = req1_b;
          owner_s     = OWNER_1;
          div_a_stb_s = 1'b1;
          state_s     = SEND_A;
        end else begin
          state_s = IDLE;
        end
      end

      SEND_A: begin
        if (div_a_stb_r && div_a_ack) begin
          div_a_stb_s = 1'b0;
          div_b_stb_s = 1'b1;
          state_s     = SEND_B;
        end else begin
          state_s = SEND_A;
        end
      end

      SEND_B: begin
        if (div_b_stb_r && div_b_ack) begin
          div_b_stb_s = 1'b0;
          div_z_ack_s = 1'b1;
          wd_cnt_s    = WD_ZERO;
          state_s     = WAIT_Z;
        end else begin
          state_s = SEND_B;
        end
      end

      WAIT_Z: begin
        if (z_xfer_s || wd_fire_s) begin
          // A real quotient and a watchdog abort differ only in payload
          if (owner_r == OWNER_0) begin
            resp0_z_s   = z_xfer_s ? div_z : Z_NAN;
            resp0_err_s = !z_xfer_s;
            resp0_stb_s = 1'b1;
          end else begin
            resp1_z_s   = z_xfer_s ? div_z : Z_NAN;
            resp1_err_s = !z_xfer_s;
            resp1_stb_s = 1'b1;
          end
          div_z_ack_s = 1'b0;
          state_s     = RESP;
        end else if (wd_cnt_r != WD_MAX) begin
          wd_cnt_s = wd_cnt_r + WD_ONE;
        end else begin
          wd_cnt_s = wd_cnt_r;
        end
      end

      RESP: begin
        if (resp_xfer_s) begin
          if (owner_r == OWNER_0) begin
            resp0_stb_s = 1'b0;
          end else begin
            resp1_stb_s = 1'b0;
          end
          last_grant_s = owner_r;
          state_s      = IDLE;
        end else begin
          state_s = RESP;
        end
      end

      default: begin
        div_a_stb_s = 1'b0;
        div_b_stb_s = 1'b0;
        div_z_ack_s = 1'b0;
        resp0_stb_s = 1'b0;
        resp1_stb_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= OWNER_0;
      last_grant_r <= OWNER_1;
      div_a_r      <= Z_ZERO;
      div_b_r      <= Z_ZERO;
      div_a_stb_r  <= 1'b0;
      div_b_stb_r  <= 1'b0;
      div_z_ack_r  <= 1'b0;
      wd_cnt_r     <= WD_ZERO;
      resp0_z_r    <= Z_ZERO;
      resp0_err_r  <= 1'b0;
      resp0_stb_r  <= 1'b0;
      resp1_z_r    <= Z_ZERO;
      resp1_err_r  <= 1'b0;
      resp1_stb_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      div_a_r      <= div_a_s;
      div_b_r      <= div_b_s;
      div_a_stb_r  <= div_a_stb_s;
      div_b_stb_r  <= div_b_stb_s;
      div_z_ack_r  <= div_z_ack_s;
      wd_cnt_r     <= wd_cnt_s;
      resp0_z_r    <= resp0_z_s;
      resp0_err_r  <= resp0_err_s;
      resp0_stb_r  <= resp0_stb_s;
      resp1_z_r    <= resp1_z_s;
      resp1_err_r  <= resp1_err_s;
      resp1_stb_r  <= resp1_stb_s;
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: a behavioural divider stub sits on the div_*
// port, expected responses are queued per requester when a request is
// accepted and compared when the arbiter hands the result back.
module tb_div_share_arbiter;
  import div_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_stb, req1_stb, req0_ack, req1_ack;
  logic [31:0] resp0_z, resp1_z;
  logic        resp0_err, resp1_err, resp0_stb, resp1_stb, resp0_ack, resp1_ack;
  logic [31:0] div_a, div_b, div_z;
  logic        div_a_stb, div_a_ack, div_b_stb, div_b_ack, div_z_stb, div_z_ack;
  logic        div_rst, busy;

  typedef struct packed {
    logic [31:0] z;
    logic        err;
  } exp_t;

  exp_t exp0_q[$];
  exp_t exp1_q[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pop0 = 0;
  int   n_pop1 = 0;
  bit   stall = 1'b0;
  int   lat = 10;

  // divider stub state
  int          ms = 0;
  int          cnt = 0;
  logic [31:0] oa = 32'd0, ob = 32'd0, ca = 32'd0, cb = 32'd0;
  bit          pa = 1'b0, pb = 1'b0, pz = 1'b0, pr = 1'b1;

  // fairness job table: even entries for requester 0, odd for requester 1
  logic [31:0] fa [6] = '{32'h40C00000, 32'h41000000, 32'h40400000,
                          32'h41100000, 32'h41200000, 32'h40000000};
  logic [31:0] fb [6] = '{32'h40000000, 32'h40000000, 32'h40000000,
                          32'h40400000, 32'h40800000, 32'h41000000};
  logic [31:0] fz [6] = '{32'h40400000, 32'h40800000, 32'h3FC00000,
                          32'h40400000, 32'h40200000, 32'h3E800000};

  always #5 clk = ~clk;

  div_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_a(req0_a), .req0_b(req0_b), .req0_stb(req0_stb), .req0_ack(req0_ack),
    .resp0_z(resp0_z), .resp0_err(resp0_err), .resp0_stb(resp0_stb), .resp0_ack(resp0_ack),
    .req1_a(req1_a), .req1_b(req1_b), .req1_stb(req1_stb), .req1_ack(req1_ack),
    .resp1_z(resp1_z), .resp1_err(resp1_err), .resp1_stb(resp1_stb), .resp1_ack(resp1_ack),
    .div_a(div_a), .div_a_stb(div_a_stb), .div_a_ack(div_a_ack),
    .div_b(div_b), .div_b_stb(div_b_stb), .div_b_ack(div_b_ack),
    .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack),
    .div_rst(div_rst), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // known IEEE single quotients used by the stub divider
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C00000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h40800000}: return 32'h3E800000;
      {32'h3F800000, 32'h00000000}: return 32'h7F800000;
      {32'h41000000, 32'h40000000}: return 32'h40800000;
      {32'h40400000, 32'h40000000}: return 32'h3FC00000;
      {32'h41100000, 32'h40400000}: return 32'h40400000;
      {32'h41200000, 32'h40800000}: return 32'h40200000;
      {32'h40000000, 32'h41000000}: return 32'h3E800000;
      default:                      return 32'h7FC00000;
    endcase
  endfunction

  // stub divider: handshakes seen at the previous edge are applied at each negedge
  initial begin
    div_a_ack = 1'b0; div_b_ack = 1'b0; div_z_stb = 1'b0; div_z = 32'd0;
    forever begin
      @(negedge clk);
      if (pr) begin
        ms = 0;
      end else begin
        case (ms)
          0: if (pa) begin oa = ca; ms = 1; end
          1: if (pb) begin ob = cb; ms = 2; cnt = lat; end
          2: if (cnt <= 1) ms = 3; else cnt--;
          3: if (pz) ms = 0;
          default: ms = 0;
        endcase
      end
      div_a_ack = (ms == 0);
      div_b_ack = (ms == 1);
      div_z_stb = (ms == 3) && !stall;
      div_z     = fdiv(oa, ob);
      #1;
      pa = div_a_stb && div_a_ack; ca = div_a;
      pb = div_b_stb && div_b_ack; cb = div_b;
      pz = div_z_stb && div_z_ack;
      pr = div_rst;
    end
  end

  // response monitor: pops and compares on each response transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (resp0_stb) begin
        if (exp0_q.size() == 0) begin
          check_val("resp0_unexpected", {31'd0, resp0_stb}, 32'd0);
        end else if (resp0_ack) begin
          e = exp0_q.pop_front();
          n_pop0++;
          check_val("resp0_z", resp0_z, e.z);
          check_val("resp0_err", {31'd0, resp0_err}, {31'd0, e.err});
        end
      end
      if (resp1_stb) begin
        if (exp1_q.size() == 0) begin
          check_val("resp1_unexpected", {31'd0, resp1_stb}, 32'd0);
        end else if (resp1_ack) begin
          e = exp1_q.pop_front();
          n_pop1++;
          check_val("resp1_z", resp1_z, e.z);
          check_val("resp1_err", {31'd0, resp1_err}, {31'd0, e.err});
        end
      end
    end
  end

  // raise a request at the current negedge, hold it until acked, queue the expected result
  task automatic do_req(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ez, input logic eerr);
    exp_t e;
    bit   done = 1'b0;
    e.z = ez;
    e.err = eerr;
    if (n == 0) begin req0_a = a; req0_b = b; req0_stb = 1'b1; end
    else        begin req1_a = a; req1_b = b; req1_stb = 1'b1; end
    for (int i = 0; i < 3000 && !done; i++) begin
      #1;
      if ((n == 0 && req0_ack) || (n == 1 && req1_ack)) begin
        done = 1'b1;
        if (n == 0) exp0_q.push_back(e);
        else        exp1_q.push_back(e);
        grant_log.push_back(n);
      end
      @(negedge clk);
    end
    if (n == 0) req0_stb = 1'b0;
    else        req1_stb = 1'b0;
    if (!done) check_val("req_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #3;
      if (!busy && exp0_q.size() == 0 && exp1_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check_val({tag, "_done"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    grant_log.delete();
  endtask

  initial begin
    int   wz;
    bit   fired;
    bit   seen;
    int   pops;
    rst = 1'b1;
    req0_a = 32'd0; req0_b = 32'd0; req0_stb = 1'b0;
    req1_a = 32'd0; req1_b = 32'd0; req1_stb = 1'b0;
    resp0_ack = 1'b1; resp1_ack = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    #2;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_resp0_stb", {31'd0, resp0_stb}, 32'd0);
    check_val("rst_resp1_stb", {31'd0, resp1_stb}, 32'd0);
    check_val("rst_resp0_z", resp0_z, 32'd0);
    check_val("rst_resp0_err", {31'd0, resp0_err}, 32'd0);
    check_val("rst_div_a_stb", {31'd0, div_a_stb}, 32'd0);
    check_val("rst_div_b_stb", {31'd0, div_b_stb}, 32'd0);
    check_val("rst_div_z_ack", {31'd0, div_z_ack}, 32'd0);
    check_val("rst_div_rst", {31'd0, div_rst}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // single request 6.0 / 2.0
    @(negedge clk);
    do_req(0, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    wait_idle("single");
    check_val("single_busy", {31'd0, busy}, 32'd0);
    check_val("single_pop0", n_pop0, 32'd1);
    check_val("single_pop1", n_pop1, 32'd0);

    // contention right after reset: requester 0 first
    do_reset();
    fork
      do_req(0, 32'h3F800000, 32'h40800000, 32'h3E800000, 1'b0);
      do_req(1, 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0);
    join
    wait_idle("contention");
    check_val("contention_grants", grant_log.size(), 32'd2);
    if (grant_log.size() == 2) begin
      check_val("contention_first", grant_log[0], 32'd0);
      check_val("contention_second", grant_log[1], 32'd1);
    end

    // fairness: both requesters keep asking, grants alternate
    grant_log.delete();
    @(negedge clk);
    fork
      begin for (int i = 0; i < 3; i++) do_req(0, fa[2*i], fb[2*i], fz[2*i], 1'b0); end
      begin for (int j = 0; j < 3; j++) do_req(1, fa[2*j+1], fb[2*j+1], fz[2*j+1], 1'b0); end
    join
    wait_idle("fair");
    check_val("fair_grants", grant_log.size(), 32'd6);
    for (int k = 0; k < grant_log.size() && k < 6; k++)
      check_val("fair_order", grant_log[k], k % 2);

    // response backpressure
    do_reset();
    resp0_ack = 1'b0;
    @(negedge clk);
    do_req(0, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    fork
      do_req(1, 32'h41000000, 32'h40000000, 32'h40800000, 1'b0);
    join_none
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (resp0_stb) seen = 1'b1;
    end
    check_val("bp_resp_seen", {31'd0, seen}, 32'd1);
    repeat (20) begin
      @(negedge clk);
      #2;
      check_val("bp_stb", {31'd0, resp0_stb}, 32'd1);
      check_val("bp_z", resp0_z, 32'h40400000);
      check_val("bp_req1_ack", {31'd0, req1_ack}, 32'd0);
    end
    @(negedge clk);
    resp0_ack = 1'b1;
    #2;
    check_val("bp_req1_ack_at_xfer", {31'd0, req1_ack}, 32'd0);
    @(negedge clk);
    #2;
    check_val("bp_req1_ack_after", {31'd0, req1_ack}, 32'd1);
    wait_idle("bp");

    // watchdog: stub never produces a result
    do_reset();
    stall = 1'b1;
    @(negedge clk);
    do_req(0, 32'h40C00000, 32'h40000000, QNAN, 1'b1);
    wz = 0;
    fired = 1'b0;
    for (int i = 0; i < 400 && !fired; i++) begin
      #2;
      if (div_rst) fired = 1'b1;
      else if (div_z_ack) wz++;
      if (!fired) @(negedge clk);
    end
    check_val("wd_fired", {31'd0, fired}, 32'd1);
    check_val("wd_cycles", wz, 32'd255);
    @(negedge clk);
    #2;
    check_val("wd_rst_pulse", {31'd0, div_rst}, 32'd0);
    stall = 1'b0;
    wait_idle("wd");

    // reset during WAIT_Z discards the job
    do_reset();
    stall = 1'b1;
    @(negedge clk);
    do_req(0, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (div_z_ack) seen = 1'b1;
    end
    check_val("mid_wait_z", {31'd0, seen}, 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp0_q.delete();
    pops = n_pop0;
    @(negedge clk);
    #2;
    check_val("mid_busy", {31'd0, busy}, 32'd0);
    check_val("mid_div_a_stb", {31'd0, div_a_stb}, 32'd0);
    check_val("mid_div_b_stb", {31'd0, div_b_stb}, 32'd0);
    check_val("mid_div_z_ack", {31'd0, div_z_ack}, 32'd0);
    check_val("mid_resp0_stb", {31'd0, resp0_stb}, 32'd0);
    check_val("mid_resp1_stb", {31'd0, resp1_stb}, 32'd0);
    check_val("mid_req0_ack", {31'd0, req0_ack}, 32'd0);
    check_val("mid_div_rst", {31'd0, div_rst}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    repeat (30) @(negedge clk);
    check_val("mid_no_resp", n_pop0, pops);
    do_req(0, 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    wait_idle("mid_after");
    check_val("mid_after_pop", n_pop0, pops + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
